// File: rtl/seg7_count_display.sv
// Shows an 8-bit binary count as decimal 000-255 on a 4-digit multiplexed common-anode display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros in the hund/tens slots.
//
// state | meaning
// IDLE  | digits stable, watching value for a change
// SHIFT | double-dabble, one bit per cycle for 8 cycles
// DONE  | commit scratch BCD to the displayed digits
module seg7_count_display #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || CLK_HZ < SCAN_DIV) begin : g_cfg_check
    $error("seg7_count_display: SCAN_DIV must be >= 2 and <= CLK_HZ");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        last_value;
  logic [7:0]        shreg;
  logic [11:0]       scratch;
  logic [11:0]       adj;
  logic [2:0]        bit_cnt;
  logic [3:0]        hund, tens, ones;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;
  logic              hund_blank, tens_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (value != last_value) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign adj  = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};

  // Digits are written only in DONE, so the display never sees a half-converted value.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_value <= 8'd0;
      shreg      <= 8'd0;
      scratch    <= 12'd0;
      bit_cnt    <= 3'd0;
      hund       <= 4'd0;
      tens       <= 4'd0;
      ones       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            last_value <= value;
            shreg      <= value;
            scratch    <= 12'd0;
            bit_cnt    <= 3'd0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        DONE: begin
          hund <= scratch[11:8];
          tens <= scratch[7:4];
          ones <= scratch[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign hund_blank = (hund == 4'd0);
  assign tens_blank = (hund == 4'd0) && (tens == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  // Slot 3 is driven but blank so every frame has four equal slots.
  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    case (digit_idx)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = decode(ones);
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = tens_blank ? 7'h7F : decode(tens);
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = hund_blank ? 7'h7F : decode(hund);
      end
      default: an_nxt = 4'b0111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

  assign dp = 1'b1;

endmodule
